fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the byte-addressed instruction memory (`ist_mem`) in the IF stage of the 5-stage pipeline. It owns the PC and drives `EnIM`/`addr` every cycle, issuing one 32-bit fetch per cycle. It honours stall and branch-redirect requests from the hazard/branch units and stops on a HALT opcode or an illegal fetch address. It also tags the instruction word coming back from memory with its PC and a valid bit for the IF/ID register.

## Interface
- `RESET_PC`, 32'h0, first fetch address after reset.
- `MEM_BYTES`, 32, instruction memory size in bytes; must be a multiple of 4.
- `HALT_OP`, 4'b1111, opcode in `instr[31:28]` that stops fetching.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  leave IDLE and begin fetching from the PC.
- `stall`  in  1  hold the PC and the fetched word; no new fetch.
- `redirect`  in  1  branch/jump taken; fetch from `redirect_pc` this cycle.
- `redirect_pc`  in  32  redirect target byte address.
- `instr`  in  32  registered memory read data, valid one cycle after `im_en`.
- `im_en`  out  1  drives memory `EnIM`.
- `im_addr`  out  32  drives memory `addr`.
- `if_pc`  out  32  PC of the word currently on `instr`.
- `if_valid`  out  1  `instr` holds a live, in-path instruction.
- `halted`  out  1  sticky; set when a HALT was fetched.
- `fault`  out  1  sticky; set on an illegal fetch address.
- `fault_addr`  out  32  the offending address, captured when `fault` sets.

## Operation
- States: IDLE, RUN, HALT, FAULT. Reset enters IDLE.
- IDLE
  - `im_en`=0.
  - `start`=1 moves to RUN; the first fetch is issued the following cycle.
- RUN: candidate address `fa` = `redirect` ? `redirect_pc` : `pc`. Priority order, highest first:
  1. Illegal `fa` (`fa[1:0]`≠0 or `fa` > `MEM_BYTES`-4): `im_en`=0, capture `fault_addr`=`fa`, go to FAULT, `if_valid`<=0.
  2. `redirect`: fetch `fa`, even if `stall` is high or a HALT is present. A HALT in IF during a redirect is wrong-path and is ignored.
  3. `if_valid` && `instr[31:28]`==`HALT_OP` && !`stall`: `im_en`=0, go to HALT, `if_valid`<=0. The HALT word itself is consumed by IF/ID this cycle.
  4. `stall`: `im_en`=0. `pc`, `if_pc` and `if_valid` hold. Memory holds `instr` because `EnIM` is low.
  5. Otherwise: fetch `fa`.
- On any fetch: `im_en`=1, `im_addr`=`fa`, `pc`<=`fa`+4, `if_pc`<=`fa`, `if_valid`<=1.
- HALT and FAULT are terminal until `rst`. In both, `im_en`=0 and `if_valid`=0. `halted`/`fault` stay at 1.
- `im_addr` = `fa` in RUN, otherwise `pc`. Its value is don't-care when `im_en`=0.
- PC arithmetic is 32-bit unsigned and wraps modulo 2^32; the range check catches the wrap.

## Timing
- Reset values: state=IDLE, `pc`=`RESET_PC`, `if_pc`=0, `if_valid`=0, `halted`=0, `fault`=0, `fault_addr`=0, `im_en`=0.
- `im_en`/`im_addr` are combinational from state, `pc` and the inputs. The memory registers the address.
- Fetch latency: fetch issued in cycle n → `instr`, `if_pc` and `if_valid` are valid in cycle n+1.
- Throughput: one fetch per cycle with no stall.
- Redirect in cycle n: the target word appears in n+1. The word already on `instr` in cycle n is flushed by the hazard unit, not by this block.
- Reset mid-operation clears everything immediately. The stale `instr` register in memory is masked by `if_valid`=0.
- Simultaneous events:
  - `stall`+`redirect`: redirect wins.
  - `start` in RUN/HALT/FAULT: ignored.
  - Illegal `redirect_pc` + HALT: fault wins.

## Structure
- Package `fetch_pkg` holds:
  - The state enum `fetch_state_t`.
  - `INSTR_BYTES`=4.
  - The default `HALT_OP`.
  - The opcode field slice constants `OP_HI`=31 and `OP_LO`=28.
- Optional combinational sub-module `fetch_addr_chk` (`fa`, `MEM_BYTES` → `illegal`), shared with the future data-memory controller.
- Everything else lives in `fetch_ctrl`.

## Test plan
- Reset, then `start` pulse with no stalls: `im_addr` sequence 0, 4, 8, 12, 16. Each `if_pc` equals the previous cycle's `im_addr`, and `if_valid`=1 from the first return on.
- `stall` high for 3 cycles while `if_pc`=8: `im_en`=0, and `if_pc`=8, `if_valid`=1 and `instr` are unchanged for all 3 cycles. Fetch resumes at 12.
- Memory word 16 = 32'hF978_0000 (HALT). After it returns: `im_en`=0, `halted`=1, and `if_valid` drops the next cycle. Address 20 is never fetched.
- `redirect`=1, `redirect_pc`=4, with `stall`=1 and the HALT word present: fetch at 4 occurs, `halted` stays 0, and the next `im_addr` is 8.
- `redirect_pc`=6 (misaligned), and separately `redirect_pc`=32 (out of range): `fault`=1 and `fault_addr`=6 (resp. 32), with `im_en`=0 and `if_valid`=0 thereafter.
- Assert `rst` for 1 cycle while RUN at `pc`=12: all outputs return to reset values within that cycle. After `start`, fetch restarts at 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its
// address checker.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    // What the RUN state does with the current cycle.
    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_FETCH = 3'd1,
        ACT_HOLD  = 3'd2,
        ACT_HALT  = 3'd3,
        ACT_FAULT = 3'd4
    } fetch_act_t;

    localparam int unsigned INSTR_BYTES     = 4;
    localparam logic [3:0]  DEFAULT_HALT_OP = 4'b1111;
    localparam int          OP_HI           = 31;
    localparam int          OP_LO           = 28;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_addr_chk.sv
// Combinational legality check for a word fetch address against a memory
// of MEM_BYTES bytes.
module fetch_addr_chk
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic [31:0] fa,
    output logic        illegal
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - INSTR_BYTES);

    // A wrapped PC lands far above LAST_WORD, so this also catches wrap.
    assign illegal = !word_aligned(fa) || (fa > LAST_WORD);

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues one word fetch per cycle,
// honours stall/redirect, and stops on HALT or an illegal fetch address.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned MEM_BYTES = 32,
    parameter logic [3:0]  HALT_OP   = DEFAULT_HALT_OP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr,
    output logic        im_en,
    output logic [31:0] im_addr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_addr
);

    generate
        if ((MEM_BYTES % INSTR_BYTES) != 0 || MEM_BYTES == 0) begin : g_bad_size
            $error("fetch_ctrl: MEM_BYTES must be a non-zero multiple of 4");
        end
    endgenerate

    fetch_state_t state, state_next;
    fetch_act_t   act;
    logic [31:0]  pc;
    logic [31:0]  fa;
    logic         illegal;
    logic         halt_seen;
    logic         unused_instr_bits;

    assign fa        = redirect ? redirect_pc : pc;
    assign halt_seen = if_valid && (instr[OP_HI:OP_LO] == HALT_OP);
    assign unused_instr_bits = ^instr[OP_LO-1:0];

    fetch_addr_chk #(
        .MEM_BYTES(MEM_BYTES)
    ) u_addr_chk (
        .fa     (fa),
        .illegal(illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Redirect outranks HALT: a HALT sitting in IF during a taken branch is wrong-path.
    always_comb begin
        act        = ACT_NONE;
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (illegal) begin
                    act        = ACT_FAULT;
                    state_next = ST_FAULT;
                end else if (redirect) begin
                    act = ACT_FETCH;
                end else if (halt_seen && !stall) begin
                    act        = ACT_HALT;
                    state_next = ST_HALT;
                end else if (stall) begin
                    act = ACT_HOLD;
                end else begin
                    act = ACT_FETCH;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    always_comb begin
        im_en   = (act == ACT_FETCH);
        im_addr = (state == ST_RUN) ? fa : pc;
        halted  = (state == ST_HALT);
        fault   = (state == ST_FAULT);
    end

    // IF/ID tag: PC and liveness of the word memory returns next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            if_pc      <= 32'h0;
            if_valid   <= 1'b0;
            fault_addr <= 32'h0;
        end else begin
            case (act)
                ACT_FETCH: begin
                    pc       <= fa + 32'(INSTR_BYTES);
                    if_pc    <= fa;
                    if_valid <= 1'b1;
                end
                ACT_HALT: begin
                    if_valid <= 1'b0;
                end
                ACT_FAULT: begin
                    fault_addr <= fa;
                    if_valid   <= 1'b0;
                end
                default: begin
                    pc       <= pc;
                    if_valid <= if_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 32-byte registered instruction memory model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr = 32'h0;
    logic        im_en;
    logic [31:0] im_addr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic        fault;
    logic [31:0] fault_addr;
    logic        fetched20 = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_ctrl #(
        .RESET_PC (32'h0),
        .MEM_BYTES(32),
        .HALT_OP  (4'b1111)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr      (instr),
        .im_en      (im_en),
        .im_addr    (im_addr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .halted     (halted),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    // Word 4 (byte 16) is the HALT word; the rest are ordinary opcodes.
    function automatic logic [31:0] mem_word(input logic [2:0] idx);
        return (idx == 3'd4) ? 32'hF978_0000 : (32'hA500_0000 | 32'(idx));
    endfunction

    always @(posedge clk) begin
        if (im_en) begin
            instr <= mem_word(im_addr[4:2]);
            if (im_addr == 32'd20) fetched20 <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the bench at the negedge of the first RUN cycle (pc = 0).
    task automatic start_run();
        start = 1'b1;
        #1 check("idle_im_en", 32'(im_en), 32'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // Reset values
        rst = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        #1;
        check("rst_im_en", 32'(im_en), 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_addr", fault_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Straight-line fetch 0..16, then HALT
        start_run();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("seq_im_en", 32'(im_en), 32'd1);
            check("seq_im_addr", im_addr, 32'(4 * k));
            if (k == 0) begin
                check("seq_first_valid", 32'(if_valid), 32'd0);
            end else begin
                check("seq_if_pc", if_pc, 32'(4 * (k - 1)));
                check("seq_if_valid", 32'(if_valid), 32'd1);
                check("seq_instr", instr, 32'hA500_0000 | 32'(k - 1));
            end
            @(negedge clk);
        end
        #1;
        check("halt_instr", instr, 32'hF978_0000);
        check("halt_if_pc", if_pc, 32'd16);
        check("halt_im_en", 32'(im_en), 32'd0);
        @(negedge clk);
        #1;
        check("halted_set", 32'(halted), 32'd1);
        check("halted_if_valid", 32'(if_valid), 32'd0);
        check("halted_im_en", 32'(im_en), 32'd0);
        start = 1'b1;
        @(negedge clk);
        #1;
        check("halted_start_ignored", 32'(im_en), 32'd0);
        check("halted_sticky", 32'(halted), 32'd1);
        check("never_fetch_20", 32'(fetched20), 32'd0);
        start = 1'b0;

        // Stall for three cycles while if_pc = 8
        do_reset();
        start_run();
        skip(3);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_im_en", 32'(im_en), 32'd0);
            check("stall_if_pc", if_pc, 32'd8);
            check("stall_if_valid", 32'(if_valid), 32'd1);
            check("stall_instr", instr, 32'hA500_0002);
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        check("resume_im_en", 32'(im_en), 32'd1);
        check("resume_im_addr", im_addr, 32'd12);
        @(negedge clk);
        #1;
        check("resume_if_pc", if_pc, 32'd12);
        check("resume_instr", instr, 32'hA500_0003);
        // Last legal word, then the sequential PC steps off the end
        redirect = 1'b1; redirect_pc = 32'd28;
        #1;
        check("last_word_im_en", 32'(im_en), 32'd1);
        check("last_word_im_addr", im_addr, 32'd28);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("past_end_im_en", 32'(im_en), 32'd0);
        check("past_end_if_pc", if_pc, 32'd28);
        check("past_end_instr", instr, 32'hA500_0007);
        @(negedge clk);
        #1;
        check("past_end_fault", 32'(fault), 32'd1);
        check("past_end_fault_addr", fault_addr, 32'd32);

        // Asynchronous reset while running at pc = 12
        do_reset();
        start_run();
        skip(3);
        #1;
        check("pre_rst_im_addr", im_addr, 32'd12);
        rst = 1'b1;
        #1;
        check("mid_rst_im_en", 32'(im_en), 32'd0);
        check("mid_rst_if_valid", 32'(if_valid), 32'd0);
        check("mid_rst_if_pc", if_pc, 32'd0);
        check("mid_rst_halted", 32'(halted), 32'd0);
        check("mid_rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_run();
        #1;
        check("restart_im_en", 32'(im_en), 32'd1);
        check("restart_im_addr", im_addr, 32'd0);

        // Redirect beats stall and an in-flight HALT; then a misaligned redirect faults
        do_reset();
        start_run();
        skip(5);
        redirect = 1'b1; redirect_pc = 32'd4; stall = 1'b1;
        #1;
        check("redir_halt_present", instr, 32'hF978_0000);
        check("redir_im_en", 32'(im_en), 32'd1);
        check("redir_im_addr", im_addr, 32'd4);
        @(negedge clk);
        redirect = 1'b0; stall = 1'b0;
        #1;
        check("redir_not_halted", 32'(halted), 32'd0);
        check("redir_if_pc", if_pc, 32'd4);
        check("redir_next_addr", im_addr, 32'd8);
        check("redir_next_en", 32'(im_en), 32'd1);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'd6;
        #1;
        check("misalign_im_en", 32'(im_en), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("misalign_fault", 32'(fault), 32'd1);
        check("misalign_fault_addr", fault_addr, 32'd6);
        check("misalign_if_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        #1;
        check("misalign_hold_en", 32'(im_en), 32'd0);
        check("misalign_hold_fault", 32'(fault), 32'd1);

        // Out-of-range redirect while a HALT is present: fault wins
        do_reset();
        start_run();
        skip(5);
        redirect = 1'b1; redirect_pc = 32'd32;
        #1;
        check("oor_im_en", 32'(im_en), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        start = 1'b1;
        #1;
        check("oor_fault", 32'(fault), 32'd1);
        check("oor_fault_addr", fault_addr, 32'd32);
        check("oor_not_halted", 32'(halted), 32'd0);
        check("oor_if_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("oor_start_ignored", 32'(im_en), 32'd0);
        check("oor_fault_sticky", 32'(fault), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
